alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU (SrcA/SrcB/aluControl -> ALUResult/zero) between two requesters.
//  Each requester posts an operation with a valid/ready handshake. The block grants requesters
//  round-robin, drives the ALU from registered operands and captures the result. It returns the
//  result to the winning requester with a valid/ready handshake.
//  It sits between the core datapath/coprocessor ports and the single shared ALU instance.
// PARAMETERS
//  WIDTH    32  operand/result width; must match the ALU
//  CTRL_W   3   aluControl width (000 add, 001 sub, 010 and, 011 or, 101 slt)
//  RR_INIT  0   requester given priority first after reset (0 or 1)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  req0_valid   in   1       requester 0 has an operation pending
//  req0_ready   out  1       requester 0 operation accepted this cycle
//  req0_srcA    in   WIDTH   requester 0 operand A
//  req0_srcB    in   WIDTH   requester 0 operand B
//  req0_ctrl    in   CTRL_W  requester 0 aluControl code
//  req1_*       ...          identical set for requester 1
//  rsp0_valid   out  1       result for requester 0 available
//  rsp0_ready   in   1       requester 0 consumes result
//  rsp1_valid   out  1       result for requester 1 available
//  rsp1_ready   in   1       requester 1 consumes result
//  rsp_result   out  WIDTH   captured ALUResult (shared by both responses)
//  rsp_zero     out  1       captured zero flag
//  SrcA         out  WIDTH   to ALU
//  SrcB         out  WIDTH   to ALU
//  aluControl   out  CTRL_W  to ALU
//  ALUResult    in   WIDTH   from ALU (combinational)
//  zero         in   1       from ALU (combinational)
// BEHAVIOUR
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE. One operation is in flight at a time.
//  - IDLE: if either reqN_valid is set, grant one requester.
//    - Both valid: grant the requester not served last (priority pointer).
//    - One valid: grant it regardless of the pointer.
//    - reqN_ready=1 only for the granted N, only in IDLE, combinational from valid and pointer.
//    - On accept (valid&&ready): latch srcA/srcB/ctrl and the grant id; go to EXEC.
//    - Pointer flips to favour the other requester on every accept.
//  - EXEC: SrcA/SrcB/aluControl are driven from the latched registers (always, in every state).
//    At the clock edge, ALUResult/zero are registered into rsp_result/rsp_zero; go to RESP.
//  - RESP: rsp{grant}_valid=1; the other rsp valid stays 0.
//    - rsp_result and rsp_zero are held stable until consumed.
//    - On rsp{grant}_ready=1, the response retires this cycle and the FSM goes to IDLE.
//    - No new request is accepted in the same cycle the response retires.
//  - Latency: accept at edge N; rsp valid from cycle N+2. Minimum 3 cycles per operation.
//  - reqN_ready is 0 in EXEC/RESP; a requester holds valid and operands until accepted.
//  - rsp_ready asserted with no rsp_valid is ignored. Valid never depends on ready.
//  - Width rules: no widening. Result and zero are taken verbatim from the ALU.
//  - Reset (async, any state, including mid-EXEC/RESP):
//    - FSM goes to IDLE; the in-flight operation is dropped.
//    - req*_ready=0 and rsp*_valid=0 until the first post-reset evaluation.
//    - rsp_result=0, rsp_zero=0; SrcA/SrcB=0, aluControl=0.
//    - Pointer=RR_INIT.
// TESTING
//  1. Reset, req0: A=4, B=2, ctrl=000 -> req0_ready at cycle 0; rsp0_valid at +2;
//     rsp_result=6, zero=0; rsp1_valid stays 0.
//  2. req1: A=5, B=5, ctrl=001 -> rsp1_valid, rsp_result=0, rsp_zero=1.
//  3. Both valid continuously after reset (RR_INIT=0) -> grant order 0,1,0,1.
//     Each response carries its own result; reqN_ready never set for both at once.
//  4. Backpressure: hold rsp0_ready=0 for 5 cycles on 0xF0 and 0x3C (ctrl=010) ->
//     rsp_result=0x30 stable, no new accept; retire on ready, next accept follows.
//  5. Assert rst_n=0 during EXEC -> all valids/ready low immediately; no response emitted.
//     Next request after reset served normally with pointer=RR_INIT.
//  6. ctrl=101, A=0xFFFFFFFF, B=1 (slt signed) -> rsp_result=1, zero=0, passed through verbatim.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int CTRL_W  = 3,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_srcA,
  input  logic [WIDTH-1:0]  req0_srcB,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_srcA,
  input  logic [WIDTH-1:0]  req1_srcB,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [WIDTH-1:0]  SrcA,
  output logic [WIDTH-1:0]  SrcB,
  output logic [CTRL_W-1:0] aluControl,
  input  logic [WIDTH-1:0]  ALUResult,
  input  logic              zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic ptr, gnt, g, idle;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CTRL_W-1:0] c_q;
  // ptr names the requester that wins when both are valid
  assign g = (req0_valid && req1_valid) ? ptr : req1_valid;
  assign idle = rst_n && state == IDLE;
  assign req0_ready = idle && req0_valid && !g;
  assign req1_ready = idle && req1_valid && g;
  assign rsp0_valid = state == RESP && !gnt;
  assign rsp1_valid = state == RESP && gnt;
  assign SrcA = a_q;
  assign SrcB = b_q;
  assign aluControl = c_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 1'(RR_INIT);
      gnt <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          gnt <= g;
          a_q <= g ? req1_srcA : req0_srcA;
          b_q <= g ? req1_srcB : req0_srcB;
          c_q <= g ? req1_ctrl : req0_ctrl;
          ptr <= ~g;
          state <= EXEC;
        end
        EXEC: begin
          rsp_result <= ALUResult;
          rsp_zero <= zero;
          state <= RESP;
        end
        RESP: if (gnt ? rsp1_ready : rsp0_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: transaction-level reference model with directed and randomized traffic
module tb_alu_arbiter;
  localparam int W = 32, C = 3;
  logic clk = 0, rst_n = 0;
  logic [1:0] rv = 0, pr = 0;
  logic [W-1:0] ra [2], rb [2];
  logic [C-1:0] rc [2];
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, zero;
  logic [W-1:0] rsp_result, SrcA, SrcB, ALUResult;
  logic [C-1:0] aluControl;
  int checks = 0, errors = 0;
  bit busy = 0, gid = 0, pri = 0;
  int age = 0;
  logic [W-1:0] er, ea;
  bit gq [$];

  alu_arbiter #(.WIDTH(W), .CTRL_W(C), .RR_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_srcA(ra[0]), .req0_srcB(rb[0]), .req0_ctrl(rc[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_srcA(ra[1]), .req1_srcB(rb[1]), .req1_ctrl(rc[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(pr[0]), .rsp1_valid(rsp1_valid), .rsp1_ready(pr[1]),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .SrcA(SrcA), .SrcB(SrcB), .aluControl(aluControl), .ALUResult(ALUResult), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, b, input logic [C-1:0] c);
    case (c)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a & b;
      3'b011: return a | b;
      3'b101: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  assign ALUResult = alu_f(SrcA, SrcB, aluControl);
  assign zero = ALUResult == 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic op(input int i, input logic [W-1:0] a, b, input logic [C-1:0] c);
    rv[i] = 1;
    ra[i] = a;
    rb[i] = b;
    rc[i] = c;
  endtask

  // One clock of traffic: inputs are already driven just after a negedge.
  task automatic cycle();
    logic [1:0] erdy, ev, acc;
    bit w;
    #1;
    w = (rv == 2'b11) ? pri : rv[1];
    erdy = (!busy && rv != 0) ? (w ? 2'b10 : 2'b01) : 2'b00;
    ev = (busy && age >= 1) ? (gid ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", {req1_ready, req0_ready}, erdy);
    chk("rsp_valid", {rsp1_valid, rsp0_valid}, ev);
    if (ev != 0) begin
      chk("rsp_result", rsp_result, er);
      chk("rsp_zero", rsp_zero, er == 0);
      chk("srcA_hold", SrcA, ea);
    end
    acc = rv & erdy;
    @(posedge clk);
    if ((ev & pr) != 0) busy = 0;
    else if (busy) age++;
    if (acc != 0) begin
      gid = acc[1];
      er = alu_f(ra[gid], rb[gid], rc[gid]);
      ea = ra[gid];
      busy = 1;
      age = 0;
      pri = ~gid;
      gq.push_back(gid);
    end
    @(negedge clk);
    if (acc != 0) rv[gid] = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_result", {rsp_zero, rsp_result}, 0);
    chk("rst_alu_in", {aluControl, SrcA, SrcB}, 0);
    busy = 0;
    pri = 0;
    rv = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [C-1:0] cs [5];
    cs = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    ra = '{0, 0}; rb = '{0, 0}; rc = '{0, 0};
    @(negedge clk);
    do_reset();
    // single add from requester 0
    pr = 2'b11;
    op(0, 4, 2, 3'b000);
    repeat (3) cycle();
    // sub to zero from requester 1
    op(1, 5, 5, 3'b001);
    cycle();
    cycle();
    #1;
    chk("t2_res", {rsp1_valid, rsp_zero, rsp_result}, {2'b11, 32'd0});
    cycle();
    // both continuously valid after reset: alternate grants
    do_reset();
    gq.delete();
    repeat (12) begin
      for (int i = 0; i < 2; i++) if (!rv[i]) op(i, $urandom, $urandom, cs[$urandom_range(0, 4)]);
      cycle();
    end
    chk("t3_order", {gq[3], gq[2], gq[1], gq[0]}, 4'b1010);
    while (busy) cycle();
    rv = 0;
    // backpressure on an AND result
    pr = 0;
    op(0, 32'hF0, 32'h3C, 3'b010);
    cycle();
    op(1, 7, 9, 3'b011);
    repeat (6) cycle();
    #1;
    chk("t4_hold", {rsp0_valid, req1_ready, rsp_result}, {2'b10, 32'h30});
    pr = 2'b11;
    repeat (4) cycle();
    // reset while the operation is executing
    op(0, 1, 2, 3'b000);
    cycle();
    do_reset();
    op(0, 3, 3, 3'b001);
    op(1, 3, 4, 3'b000);
    cycle();
    chk("t5_ptr", gid, 0);
    repeat (4) cycle();
    // signed set-less-than
    rv = 0;
    op(1, 32'hFFFF_FFFF, 1, 3'b101);
    repeat (3) cycle();
    chk("t6_slt", er, 1);
    cycle();
    // randomized traffic and backpressure
    repeat (400) begin
      for (int i = 0; i < 2; i++)
        if (!rv[i] && $urandom_range(0, 2) != 0) begin
          logic [W-1:0] a;
          a = $urandom;
          op(i, a, $urandom_range(0, 3) == 0 ? a : $urandom, cs[$urandom_range(0, 4)]);
        end
      pr = 2'($urandom);
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
